// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-level round-robin mux of AXI-Stream sources onto one master stream
module axis_rr_arbiter #(
    parameter int byte_width = 4,
    parameter int num_inputs = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [num_inputs-1:0]              s_tvalid,
    output logic [num_inputs-1:0]              s_tready,
    input  logic [num_inputs*8*byte_width-1:0] s_tdata,
    input  logic [num_inputs-1:0]              s_tlast,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [8*byte_width-1:0]            m_tdata,
    output logic                               m_tlast,
    output logic [num_inputs-1:0]              grant
);

    localparam int DW = 8 * byte_width;
    localparam int IW = (num_inputs > 2) ? 2 : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_g;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_g_next;
    logic [IW-1:0]   w_ptr_next;
    logic [IW-1:0]   w_sel;
    logic            w_found;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_sel   = r_ptr;
        w_found = 1'b0;
        for (int k = num_inputs - 1; k >= 0; k--) begin
            int            j;
            logic [IW-1:0] idx;
            j = int'(r_ptr) + k;
            if (j >= num_inputs) begin
                j = j - num_inputs;
            end
            idx = IW'(j);
            if (s_tvalid[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_g_next     = r_g;
        w_ptr_next   = r_ptr;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tlast      = 1'b0;
        s_tready     = '0;
        grant        = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = BUSY;
                    w_g_next     = w_sel;
                end
            end
            BUSY: begin
                m_tvalid      = s_tvalid[r_g];
                m_tdata       = s_tdata[r_g*DW +: DW];
                m_tlast       = s_tlast[r_g];
                s_tready[r_g] = m_tready;
                grant[r_g]    = 1'b1;
                // Only the accepted tlast beat releases the owner.
                if (s_tvalid[r_g] && m_tready && s_tlast[r_g]) begin
                    w_state_next = IDLE;
                    w_ptr_next   = (r_g == IW'(num_inputs - 1)) ? '0 : r_g + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_g     <= w_g_next;
            r_ptr   <= w_ptr_next;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - directed self-checking bench for axis_rr_arbiter
module tb_axis_rr_arbiter;

    logic        clk;
    logic        resetn;

    logic [1:0]  sa_tvalid;
    logic [1:0]  sa_tready;
    logic [63:0] sa_tdata;
    logic [1:0]  sa_tlast;
    logic        ma_tvalid;
    logic        ma_tready;
    logic [31:0] ma_tdata;
    logic        ma_tlast;
    logic [1:0]  grant_a;

    logic [2:0]  sb_tvalid;
    logic [2:0]  sb_tready;
    logic [95:0] sb_tdata;
    logic [2:0]  sb_tlast;
    logic        mb_tvalid;
    logic        mb_tready;
    logic [31:0] mb_tdata;
    logic        mb_tlast;
    logic [2:0]  grant_b;

    int n_checks;
    int n_errors;

    axis_rr_arbiter #(.byte_width(4), .num_inputs(2)) u_dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (sa_tvalid),
        .s_tready (sa_tready),
        .s_tdata  (sa_tdata),
        .s_tlast  (sa_tlast),
        .m_tvalid (ma_tvalid),
        .m_tready (ma_tready),
        .m_tdata  (ma_tdata),
        .m_tlast  (ma_tlast),
        .grant    (grant_a)
    );

    axis_rr_arbiter #(.byte_width(4), .num_inputs(3)) u_dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (sb_tvalid),
        .s_tready (sb_tready),
        .s_tdata  (sb_tdata),
        .s_tlast  (sb_tlast),
        .m_tvalid (mb_tvalid),
        .m_tready (mb_tready),
        .m_tdata  (mb_tdata),
        .m_tlast  (mb_tlast),
        .grant    (grant_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] l, input logic rdy);
        sa_tvalid = v;
        sa_tdata  = {d1, d0};
        sa_tlast  = l;
        ma_tready = rdy;
    endtask

    task automatic test_reset();
        tick();
        resetn = 1'b0;
        drive_a(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        sb_tvalid = 3'b000;
        sb_tdata  = '0;
        sb_tlast  = 3'b111;
        mb_tready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (grant_a !== 2'b00 || ma_tvalid !== 1'b0 || ma_tlast !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_a_ctrl: grant=%b m_tvalid=%b m_tlast=%b expected 00 0 0", grant_a, ma_tvalid, ma_tlast);
        end
        n_checks++;
        if (ma_tdata !== 32'h0 || sa_tready !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_a_data: m_tdata=%h s_tready=%b expected 0 00", ma_tdata, sa_tready);
        end
        n_checks++;
        if (grant_b !== 3'b000 || mb_tvalid !== 1'b0 || sb_tready !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_b: grant=%b m_tvalid=%b s_tready=%b expected 000 0 000", grant_b, mb_tvalid, sb_tready);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g [0:7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [31:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                resetn = 1'b1;
                drive_a(2'b11, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 1'b1);
            end
            #1;
            exp_d = (exp_g[i] == 2'b01) ? 32'hA0A0A0A0 : (exp_g[i] == 2'b10) ? 32'hB1B1B1B1 : 32'h0;
            n_checks++;
            if (grant_a !== exp_g[i] || ma_tvalid !== (exp_g[i] != 2'b00) || ma_tdata !== exp_d) begin
                n_errors++;
                $display("FAIL round_robin[%0d]: grant=%b m_tvalid=%b m_tdata=%h expected %b %b %h",
                         i, grant_a, ma_tvalid, ma_tdata, exp_g[i], (exp_g[i] != 2'b00), exp_d);
            end
        end
        tick();
        drive_a(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        #1;
        n_checks++;
        if (grant_a !== 2'b00) begin
            n_errors++;
            $display("FAIL round_robin_end: grant=%b expected 00", grant_a);
        end
    endtask

    task automatic test_backpressure();
        logic        v1  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] d1  [0:6] = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'h0};
        logic        l1  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        rdy [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  eg  [0:6] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [31:0] ed  [0:6] = '{32'h0, 32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'h0};
        logic        el  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]  esr [0:6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        int hs = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            drive_a({v1[i], 1'b0}, 32'h0, d1[i], {l1[i], 1'b0}, rdy[i]);
            #1;
            if (ma_tvalid && ma_tready) hs++;
            n_checks++;
            if (grant_a !== eg[i] || ma_tdata !== ed[i] || ma_tlast !== el[i] || sa_tready !== esr[i]) begin
                n_errors++;
                $display("FAIL backpressure[%0d]: grant=%b m_tdata=%h m_tlast=%b s_tready=%b expected %b %h %b %b",
                         i, grant_a, ma_tdata, ma_tlast, sa_tready, eg[i], ed[i], el[i], esr[i]);
            end
        end
        n_checks++;
        if (hs !== 3) begin
            n_errors++;
            $display("FAIL backpressure_beats: handshakes=%0d expected 3", hs);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  v   [0:7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
        logic [31:0] d0  [0:7] = '{32'h20, 32'h20, 32'h21, 32'h21, 32'h22, 32'h0, 32'h0, 32'h0};
        logic [1:0]  l   [0:7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
        logic [1:0]  eg  [0:7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        logic        ev  [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ed  [0:7] = '{32'h0, 32'h20, 32'h21, 32'h21, 32'h22, 32'h0, 32'h30, 32'h0};
        logic        el  [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  esr [0:7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 8; i++) begin
            tick();
            drive_a(v[i], d0[i], 32'h30, l[i], 1'b1);
            #1;
            n_checks++;
            if (grant_a !== eg[i] || ma_tvalid !== ev[i] || ma_tdata !== ed[i] ||
                ma_tlast !== el[i] || sa_tready !== esr[i]) begin
                n_errors++;
                $display("FAIL contention[%0d]: grant=%b m_tvalid=%b m_tdata=%h m_tlast=%b s_tready=%b expected %b %b %h %b %b",
                         i, grant_a, ma_tvalid, ma_tdata, ma_tlast, sa_tready, eg[i], ev[i], ed[i], el[i], esr[i]);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        logic        rst [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  v   [0:6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [31:0] d0  [0:6] = '{32'h0, 32'h0, 32'h0, 32'h50, 32'h50, 32'h0, 32'h0};
        logic [31:0] d1  [0:6] = '{32'h40, 32'h40, 32'h41, 32'h42, 32'h42, 32'h0, 32'h0};
        logic [1:0]  l   [0:6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [1:0]  eg  [0:6] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        logic        ev  [0:6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ed  [0:6] = '{32'h0, 32'h40, 32'h41, 32'h0, 32'h50, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            tick();
            resetn = rst[i];
            drive_a(v[i], d0[i], d1[i], l[i], 1'b1);
            #1;
            n_checks++;
            if (grant_a !== eg[i] || ma_tvalid !== ev[i] || ma_tdata !== ed[i]) begin
                n_errors++;
                $display("FAIL reset_midpacket[%0d]: grant=%b m_tvalid=%b m_tdata=%h expected %b %b %h",
                         i, grant_a, ma_tvalid, ma_tdata, eg[i], ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_three_inputs();
        logic [2:0]  v  [0:8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b000};
        logic [2:0]  eg [0:8] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        logic [31:0] ed;
        for (int i = 0; i < 9; i++) begin
            tick();
            sb_tvalid = v[i];
            sb_tdata  = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
            sb_tlast  = 3'b111;
            mb_tready = 1'b1;
            #1;
            ed = (eg[i] == 3'b100) ? 32'hCCCC0002 : (eg[i] == 3'b001) ? 32'hAAAA0000 : 32'h0;
            n_checks++;
            if (grant_b !== eg[i] || mb_tvalid !== (eg[i] != 3'b000) || mb_tdata !== ed) begin
                n_errors++;
                $display("FAIL three_inputs[%0d]: grant=%b m_tvalid=%b m_tdata=%h expected %b %b %h",
                         i, grant_b, mb_tvalid, mb_tdata, eg[i], (eg[i] != 3'b000), ed);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        sa_tvalid = '0;
        sa_tdata  = '0;
        sa_tlast  = '0;
        ma_tready = 1'b1;
        sb_tvalid = '0;
        sb_tdata  = '0;
        sb_tlast  = '0;
        mb_tready = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_contention();
        test_reset_midpacket();
        test_three_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL have parameter byte_width, default 4: data bytes per beat; m_tdata and each s_tdata lane are 8*byte_width bits.
REQ-002 The block SHALL have parameter num_inputs, default 2: number of slave streams, legal range 2..4.
REQ-003 The block SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-004 The block SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port s_tvalid, input, num_inputs: per-source valid, bit i belongs to source i.
REQ-006 The block SHALL have port s_tready, output, num_inputs: per-source ready.
REQ-007 The block SHALL have port s_tdata, input, num_inputs*8*byte_width: source i occupies bits [i*8*byte_width +: 8*byte_width].
REQ-008 The block SHALL have port s_tlast, input, num_inputs: per-source end-of-packet.
REQ-009 The block SHALL have ports m_tvalid output 1, m_tready input 1, m_tdata output 8*byte_width and m_tlast output 1, forming the shared master stream.
REQ-010 The block SHALL have port grant, output, num_inputs: one-hot owner of the master stream, all-zero when idle.

Function
REQ-011 The block SHALL implement two states: IDLE (no owner) and BUSY (one owner, index g).
REQ-012 In IDLE, m_tvalid, m_tlast, s_tready and grant SHALL be 0, and m_tdata SHALL be 0.
REQ-013 In IDLE with any s_tvalid bit set, the block SHALL select the first set bit, searching ptr, ptr+1, ... modulo num_inputs, and enter BUSY with that index as g on the next edge.
REQ-014 Arbitration latency SHALL be exactly one cycle: a request first seen in IDLE at edge N appears on m_tvalid in the cycle after edge N.
REQ-015 In IDLE with s_tvalid all zero, the block SHALL remain in IDLE.
REQ-016 In BUSY, m_tvalid, m_tdata and m_tlast SHALL combinationally equal source g's signals, s_tready[g] SHALL equal m_tready, and every other s_tready bit SHALL be 0.
REQ-017 Grant SHALL NOT change during a packet; BUSY exits only on a beat where m_tvalid, m_tready and m_tlast are all 1.
REQ-018 On that final beat, the block SHALL go to IDLE and set ptr to (g+1) modulo num_inputs.
REQ-019 A packet whose first beat carries tlast SHALL be a legal single-beat packet.
REQ-020 Every packet SHALL be followed by exactly one IDLE cycle before the next grant, including when the same source requests again.
REQ-021 In BUSY, deassertion of s_tvalid[g] SHALL NOT release the grant; the block waits for tlast.
REQ-022 Transfers SHALL be forwarded losslessly and in order: each master handshake corresponds to exactly one handshake on source g.

Reset
REQ-023 While resetn is 0 at a rising edge, the block SHALL enter IDLE and set ptr to 0, so that the outputs of REQ-012 hold in the following cycle.
REQ-024 A reset asserted mid-packet SHALL abandon the packet with no further beats forwarded; the packet SHALL NOT resume after reset.
REQ-025 In the first cycle after resetn rises, the block SHALL be in IDLE with source 0 at highest priority.

Verification
REQ-026 Verification SHALL cover: after reset, s_tvalid=2'b11 with single-beat packets and m_tready=1 -> grants in the order 0,1,0,1, with IDLE gaps between them.
REQ-027 Verification SHALL cover: source 1 sends a 3-beat packet 0x10,0x11,0x12 (tlast on 0x12) with m_tready toggling 1,0,1,0,1 -> m_tdata is 0x10,0x11,0x12 with no duplicates, and grant=2'b10 throughout.
REQ-028 Verification SHALL cover: source 0 busy while source 1 raises s_tvalid mid-packet -> s_tready[1] stays 0 until source 0's tlast, then grant=2'b10 after one IDLE cycle.
REQ-029 Verification SHALL cover: resetn=0 during beat 2 of a 4-beat packet -> in the next cycle m_tvalid=0, grant=0, and source 0 wins next.
REQ-030 Verification SHALL cover: num_inputs=3 with only source 2 requesting repeatedly -> every packet is granted to source 2 with a 1-cycle gap, and ptr wraps to 0.
REQ-031 Formal verification SHALL prove: a master stream monitor shows no AXI-Stream violation, grant is always one-hot or zero, m_tvalid=0 whenever grant=0, and m_tdata is stable while m_tvalid is high and m_tready is low, given sources that obey AXI-Stream.
